mult_div_sequencer: RTL

//  Multi-cycle signed MULT/DIV engine, sequenced by the main control unit during MULT/DIV states.

---
 rtl/mult_div_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mult_div_sequencer.sv
// Multi-cycle signed MULT/DIV engine with HI/LO result registers.
// Booth radix-2 multiply, restoring divide on magnitudes with sign fix-up.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] Op_A,
  input  logic [WIDTH-1:0] Op_B,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]  count;
  logic           op_r;
  logic           sign_a;
  logic           neg_q;
  logic           dz;
  logic           q1;
  logic [WIDTH:0] acc_hi;
  logic [WIDTH:0] opb;
  logic [WIDTH-1:0] acc_lo;

  logic             div_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign div_zero = Op && (Op_B == '0);
  assign mag_a    = Op_A[WIDTH-1] ? -Op_A : Op_A;
  assign mag_b    = Op_B[WIDTH-1] ? -Op_B : Op_B;

  // Upper half carries one guard bit so -2^(W-1) multiplicands cannot overflow
  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], q1})
      2'b01:   booth_sum = acc_hi + opb;
      2'b10:   booth_sum = acc_hi - opb;
      default: booth_sum = acc_hi;
    endcase
  end

  assign shl     = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign diff    = {1'b0, shl} - {1'b0, opb};
  assign quo_fix = neg_q ? -acc_lo : acc_lo;
  assign rem_fix = sign_a ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = div_zero ? DONE : RUN;
      RUN:  if (count == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count  <= '0;
      op_r   <= 1'b0;
      sign_a <= 1'b0;
      neg_q  <= 1'b0;
      dz     <= 1'b0;
      q1     <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (Start) begin
            op_r   <= Op;
            sign_a <= Op_A[WIDTH-1];
            neg_q  <= Op_A[WIDTH-1] ^ Op_B[WIDTH-1];
            dz     <= div_zero;
            q1     <= 1'b0;
            acc_hi <= '0;
            if (Op) begin
              acc_lo <= mag_a;
              opb    <= {1'b0, mag_b};
            end else begin
              acc_lo <= Op_B;
              opb    <= {Op_A[WIDTH-1], Op_A};
            end
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (op_r) begin
            if (!diff[WIDTH+1]) begin
              acc_hi <= diff[WIDTH:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= shl;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
            q1     <= acc_lo[0];
          end
        end
        FIX: begin
          if (op_r) begin
            HI <= rem_fix;
            LO <= quo_fix;
          end else begin
            HI <= acc_hi[WIDTH-1:0];
            LO <= acc_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy     = (state == RUN) || (state == FIX);
  assign Done     = (state == DONE);
  assign Div_Zero = (state == DONE) && dz;

endmodule
